// File: rtl/io_clk_gen_mc.sv
// Multi-channel IO-programmable fractional clock generator with glitch-free reprogramming.
// Define IO_CLK_GEN_FRAC_EN to build the fractional accumulator; otherwise half-periods are I.
module io_clk_gen_mc #(
  parameter logic [15:0]      CAddrBase = 16'h0000,
  parameter int unsigned      CChCnt    = 4,
  parameter int unsigned      CIntW     = 12,
  parameter int unsigned      CFraW     = 4,
  parameter logic [CIntW-1:0] CIntReset = 12'h00A,
  parameter logic             CEnReset  = 1'b1
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic [15:0]       AIoAddr,
  input  logic [63:0]       AIoMosi,
  input  logic [3:0]        AIoWrSize,
  output logic              AIoAddrAck,
  output logic              AIoAddrErr,
  input  logic              ASyncI,
  output logic [CChCnt-1:0] AClkOut,
  output logic [CChCnt-1:0] ACascadeO
);

  localparam logic [CIntW-1:0] IntOne   = CIntW'(1);
  localparam logic             RunReset = CEnReset && (CIntReset != '0);
  localparam logic [CIntW-1:0] CntReset = RunReset ? CIntReset - IntOne : '0;

  logic [15:0]       off;
  logic [3:0]        div_idx;
  logic              div_hit, ctrl_hit, hit, wr_ok, ctrl_wr;
  logic [CChCnt-1:0] mask_q;
  logic              unused_mosi;

  // Only the low word carries data; the upper word is accepted and dropped.
  assign unused_mosi = ^AIoMosi;

  always_comb begin
    off        = AIoAddr - CAddrBase;
    div_idx    = off[5:2];
    div_hit    = (off < 16'(4 * CChCnt)) && (off[1:0] == 2'b00);
    ctrl_hit   = (off == 16'h0040);
    hit        = div_hit || ctrl_hit;
    AIoAddrAck = hit && (AIoWrSize == 4'd4);
    AIoAddrErr = hit && (AIoWrSize != 4'd0) && (AIoWrSize != 4'd4);
    wr_ok      = AClkHEn && AIoAddrAck;
    ctrl_wr    = wr_ok && ctrl_hit;
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      mask_q <= '0;
    end else if (ctrl_wr) begin
      mask_q <= AIoMosi[CChCnt-1:0];
    end
  end

  for (genvar ch = 0; ch < CChCnt; ch++) begin : g_ch
    logic             en_q, run_q, q_q;
    logic             wr_div, restart, en_nxt, go_held, carry;
    logic [CIntW-1:0] int_q, cnt_q, int_nxt, cnt_reload;
`ifdef IO_CLK_GEN_FRAC_EN
    logic [CFraW-1:0] fra_q, acc_q, fra_nxt, acc_reload;
    logic [CFraW:0]   acc_sum;
`endif

    always_comb begin
      wr_div  = wr_ok && div_hit && (div_idx == 4'(ch));
      en_nxt  = wr_div ? AIoMosi[31] : en_q;
      int_nxt = wr_div ? AIoMosi[CFraW+CIntW-1:CFraW] : int_q;
      restart = (ctrl_wr && AIoMosi[31] && AIoMosi[ch]) || (ASyncI && mask_q[ch]);
      // A zero half-period only takes effect at a reload or restart, so no runt pulse.
      go_held = !en_nxt || ((int_nxt == '0) && (!run_q || restart || (cnt_q == '0)));
`ifdef IO_CLK_GEN_FRAC_EN
      fra_nxt    = wr_div ? AIoMosi[CFraW-1:0] : fra_q;
      acc_sum    = {1'b0, acc_q} + {1'b0, fra_nxt};
      carry      = acc_sum[CFraW];
      acc_reload = acc_sum[CFraW-1:0];
`else
      carry      = 1'b0;
`endif
      cnt_reload = carry ? int_nxt : int_nxt - IntOne;
    end

    always_ff @(posedge AClkH) begin
      if (AResetH) begin
        en_q  <= CEnReset;
        int_q <= CIntReset;
        run_q <= RunReset;
        cnt_q <= CntReset;
        q_q   <= 1'b0;
`ifdef IO_CLK_GEN_FRAC_EN
        fra_q <= '0;
        acc_q <= '0;
`endif
      end else if (AClkHEn) begin
        en_q  <= en_nxt;
        int_q <= int_nxt;
`ifdef IO_CLK_GEN_FRAC_EN
        fra_q <= fra_nxt;
`endif
        if (go_held) begin
          run_q <= 1'b0;
          q_q   <= 1'b0;
          cnt_q <= '0;
`ifdef IO_CLK_GEN_FRAC_EN
          acc_q <= '0;
`endif
        end else if (!run_q || restart) begin
          // Enable edge and restart share the same phase-aligned start point.
          run_q <= 1'b1;
          q_q   <= 1'b0;
          cnt_q <= int_nxt - IntOne;
`ifdef IO_CLK_GEN_FRAC_EN
          acc_q <= '0;
`endif
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - IntOne;
        end else begin
          q_q   <= !q_q;
          cnt_q <= cnt_reload;
`ifdef IO_CLK_GEN_FRAC_EN
          acc_q <= acc_reload;
`endif
        end
      end
    end

    assign AClkOut[ch]   = q_q;
    assign ACascadeO[ch] = en_q && (int_q != '0) && (cnt_q == '0) && q_q;
  end

endmodule
